mem_stage: RTL and testbench
============================

# mem_stage

Load/store stage placed between the execute stage and the register-file write port of the MIPS core. ALU operations pass through combinationally to writeback. Memory operations run a small FSM that issues one request on a word-wide data bus, waits for an acknowledge, and aligns or extends the returned data. While a memory operation is in flight, the stage stalls instruction fetch.

## Interface
- `TIMEOUT`, default 16: maximum number of WAIT cycles without `dbus_ack` before the access is aborted.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `op` input 6: operation code from execute. Non-memory codes pass through.
- `aluData` input 32: execute result. Used as the writeback value, or as the byte address for memory ops.
- `storeData` input 32: register b value, used for stores.
- `regcWrite_i` input 1: writeback enable from execute.
- `regcAddr_i` input 5: writeback register from execute.
- `regcWrite` output 1: register-file write enable.
- `regcAddr` output 5: register-file write address.
- `regcData` output 32: register-file write data.
- `stall` output 1: holds PC and the instruction in place while high.
- `err` output 1: one-cycle pulse for a misaligned or timed-out access.
- `dbus_req` output 1: request valid.
- `dbus_we` output 1: 1 = write.
- `dbus_addr` output 32: word address; bits [1:0] are always 0.
- `dbus_be` output 4: byte enables; bit i enables byte lane i.
- `dbus_wdata` output 32: write data.
- `dbus_ack` input 1: request completed; also means read data is valid.
- `dbus_rdata` input 32: read data.

## Operation
- Memory op codes: Lw 100011, Lb 100000, Lbu 100100, Sw 101011, Sb 101000. All other codes are non-memory.
- Non-memory op in IDLE:
  - `regcWrite`/`regcAddr` = `regcWrite_i`/`regcAddr_i`; `regcData` = `aluData`.
  - `stall` = 0. No bus activity.
- Memory op in IDLE:
  - `stall` = 1 combinationally; `regcWrite` = 0.
  - Word op with `aluData[1:0]` ≠ 0 is misaligned: go to DONE with the error flag set; no request is issued.
  - Otherwise capture the request and go to WAIT.
- Captured request fields:
  - Address: `{aluData[31:2],2'b00}`.
  - `dbus_we` = store.
  - Byte enables: 4'b1111 for word ops; 4'b0001 << `aluData[1:0]` for byte ops.
  - Write data: `storeData` for Sw; `{4{storeData[7:0]}}` for Sb.
  - Also captured: byte offset, load kind, `regcAddr_i`.
- WAIT:
  - `dbus_req` = 1 and all bus outputs are stable from registers; `stall` = 1.
  - `dbus_ack` sampled high: capture `dbus_rdata`, go to DONE.
  - `TIMEOUT` consecutive cycles without ack: go to DONE with the error flag set, and drop `dbus_req`.
  - An ack in the same cycle the counter expires wins; that access is not an error.
- DONE:
  - `stall` = 0; `err` = error flag; `dbus_req` = 0. Next edge goes to IDLE.
  - Load without error: `regcWrite` = 1, `regcAddr` = captured address.
  - Store, or any error: `regcWrite` = 0.
  - Load data, little-endian: Lw = word. Lb = selected byte sign-extended. Lbu = selected byte zero-extended.
- Reset (asserted at any time, including mid-WAIT):
  - State returns to IDLE.
  - `dbus_req`, `dbus_we`, `dbus_be`, `dbus_addr`, `dbus_wdata`, `err` = 0.
  - Timeout counter cleared.
  - While `rst` is high, `regcWrite` = 0, `regcData` = 0, `stall` = 0.
- Writes to register 0 are not filtered here; the register file ignores them.

## Timing
- Non-memory op: 0 added latency; no stall cycles.
- Memory op with ack on the first WAIT cycle: 3 cycles (IDLE, WAIT, DONE).
  - `stall` is high for the IDLE and WAIT cycles, 2 cycles total.
  - Each extra WAIT cycle adds one.
- Misaligned op: 2 cycles (IDLE, DONE); no `dbus_req`.
- Timeout: DONE is entered on the edge after the `TIMEOUT`-th unacknowledged WAIT cycle.
- Bus rules:
  - Once raised, `dbus_req` stays high with unchanged `dbus_addr`/`dbus_we`/`dbus_be`/`dbus_wdata` until the edge on which ack is sampled, or until timeout.
  - `dbus_ack` outside WAIT is ignored.
- The instruction, `op` and `aluData` are held stable by `stall`. The FSM samples them only in IDLE.

## Structure
- Shared package holds:
  - Memory op-code constants, alongside the existing op codes.
  - FSM state encoding: IDLE, WAIT, DONE.
  - Valid/Invalid and reset-level constants.
- Sub-module `mem_align`, purely combinational:
  - Store side: byte offset + store data → byte enables and write data.
  - Load side: byte offset + load kind + read data → writeback value.
- FSM, timeout counter and capture registers live in `mem_stage`.

## Test plan
- ALU pass-through: `op`=Or, `aluData`=0x00001100, `regcAddr_i`=7 → same cycle `regcWrite`=1, `regcAddr`=7, `regcData`=0x00001100, `stall`=0, `dbus_req`=0.
- Sw then Lw to 0x40:
  - Store data 0xDEADBEEF, ack after 2 WAIT cycles → `dbus_we`=1, `dbus_be`=1111, `stall` high for 3 cycles.
  - Lw, bus returns 0xDEADBEEF → `regcData`=0xDEADBEEF, `regcWrite`=1 in DONE only.
- Byte ops at 0x43:
  - Sb with `storeData`=0x000000A5 → `dbus_be`=1000, `dbus_wdata`=0xA5A5A5A5.
  - Lb, rdata 0xA5000000 → 0xFFFFFFA5.
  - Lbu, same rdata → 0x000000A5.
- Misaligned Lw at 0x42 → no `dbus_req`, `err` pulse 1 cycle, `regcWrite`=0, `stall` high 1 cycle.
- Timeout: no ack for `TIMEOUT` cycles → `dbus_req` drops, `err`=1 for 1 cycle, no writeback. Same setup with ack arriving on cycle 16 → normal completion, `err`=0.
- Reset asserted mid-WAIT → `dbus_req`=0 immediately without waiting for a clock edge. After release, the next Lw completes in 3 cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the load/store stage: op codes, FSM states, load kinds
// and the small decode helpers used by mem_stage.
package mem_stage_pkg;

    // Existing execute op codes (subset) alongside the memory op codes.
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_SB      = 6'b101000;

    localparam logic VALID       = 1'b1;
    localparam logic INVALID     = 1'b0;
    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LK_WORD  = 2'd0,
        LK_BYTE  = 2'd1,
        LK_BYTEU = 2'd2
    } load_kind_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: is_mem_op = VALID;
            default:                            is_mem_op = INVALID;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SW, OP_SB: is_store = VALID;
            default:      is_store = INVALID;
        endcase
    endfunction

    function automatic logic is_word_op(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: is_word_op = VALID;
            default:      is_word_op = INVALID;
        endcase
    endfunction

    function automatic load_kind_t load_kind_of(input logic [5:0] op);
        case (op)
            OP_LB:   load_kind_of = LK_BYTE;
            OP_LBU:  load_kind_of = LK_BYTEU;
            default: load_kind_of = LK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Word-wide data bus between the load/store stage (master) and memory (slave).
interface mem_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store-side enables/replication and
// load-side byte selection with sign or zero extension (little-endian).
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic        st_byte,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_offset,
    input  load_kind_t  load_kind,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0] sel_byte_s;

    // Store side: lane enables and write data
    always_comb begin
        if (st_byte) begin
            be    = 4'b0001 << st_offset;
            wdata = {4{store_data[7:0]}};
        end else begin
            be    = 4'b1111;
            wdata = store_data;
        end
    end

    // Load side: pick the addressed byte lane
    always_comb begin
        case (ld_offset)
            2'd0:    sel_byte_s = rdata[7:0];
            2'd1:    sel_byte_s = rdata[15:8];
            2'd2:    sel_byte_s = rdata[23:16];
            2'd3:    sel_byte_s = rdata[31:24];
            default: sel_byte_s = rdata[7:0];
        endcase
    end

    // Load side: extend to the writeback value
    always_comb begin
        case (load_kind)
            LK_WORD:  load_data = rdata;
            LK_BYTE:  load_data = {{24{sel_byte_s[7]}}, sel_byte_s};
            LK_BYTEU: load_data = {24'h000000, sel_byte_s};
            default:  load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Load/store stage: ALU results pass straight to writeback; memory ops run an
// IDLE/WAIT/DONE FSM that issues one bus request and stalls fetch meanwhile.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [31:0] aluData,
    input  logic [31:0] storeData,
    input  logic        regcWrite_i,
    input  logic [4:0]  regcAddr_i,
    output logic        regcWrite,
    output logic [4:0]  regcAddr,
    output logic [31:0] regcData,
    output logic        stall,
    output logic        err,
    mem_stage_if.master dbus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    logic            req_r;
    logic            we_r;
    logic [31:0]     addr_r;
    logic [3:0]      be_r;
    logic [31:0]     wdata_r;
    logic [31:0]     rdata_r;
    logic [1:0]      offset_r;
    load_kind_t      kind_r;
    logic            store_r;
    logic            err_flag_r;
    logic [4:0]      waddr_r;

    logic            mem_op_s;
    logic            misalign_s;
    logic            timeout_s;
    logic [3:0]      align_be_s;
    logic [31:0]     align_wdata_s;
    logic [31:0]     load_data_s;

    assign mem_op_s   = is_mem_op(op);
    assign misalign_s = mem_op_s && is_word_op(op) && (aluData[1:0] != 2'b00);
    assign timeout_s  = (cnt_r == CNT_LAST);

    mem_align u_align (
        .st_offset  (aluData[1:0]),
        .st_byte    (!is_word_op(op)),
        .store_data (storeData),
        .be         (align_be_s),
        .wdata      (align_wdata_s),
        .ld_offset  (offset_r),
        .load_kind  (kind_r),
        .rdata      (rdata_r),
        .load_data  (load_data_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; an ack in the expiry cycle takes priority
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    state_nxt_s = misalign_s ? ST_DONE : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dbus.dbus_ack || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request capture, bus registers, timeout counter and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            req_r      <= INVALID;
            we_r       <= 1'b0;
            addr_r     <= 32'h00000000;
            be_r       <= 4'b0000;
            wdata_r    <= 32'h00000000;
            rdata_r    <= 32'h00000000;
            offset_r   <= 2'b00;
            kind_r     <= LK_WORD;
            store_r    <= 1'b0;
            err_flag_r <= 1'b0;
            waddr_r    <= 5'd0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        err_flag_r <= misalign_s;
                        offset_r   <= aluData[1:0];
                        kind_r     <= load_kind_of(op);
                        store_r    <= is_store(op);
                        waddr_r    <= regcAddr_i;
                        cnt_r      <= '0;
                        if (!misalign_s) begin
                            req_r   <= VALID;
                            we_r    <= is_store(op);
                            addr_r  <= {aluData[31:2], 2'b00};
                            be_r    <= align_be_s;
                            wdata_r <= align_wdata_s;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dbus.dbus_ack) begin
                        rdata_r <= dbus.dbus_rdata;
                        req_r   <= INVALID;
                    end else if (timeout_s) begin
                        req_r      <= INVALID;
                        err_flag_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    req_r <= INVALID;
                end
                default: begin
                    req_r <= INVALID;
                end
            endcase
        end
    end

    // Writeback, stall and error outputs; ALU results bypass the FSM
    always_comb begin
        regcWrite = 1'b0;
        regcAddr  = regcAddr_i;
        regcData  = aluData;
        stall     = 1'b0;
        err       = 1'b0;
        if (rst == RST_ENABLE) begin
            regcData = 32'h00000000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        stall = 1'b1;
                    end else begin
                        regcWrite = regcWrite_i;
                    end
                end
                ST_WAIT: begin
                    stall = 1'b1;
                end
                ST_DONE: begin
                    err       = err_flag_r;
                    regcAddr  = waddr_r;
                    regcData  = load_data_s;
                    regcWrite = !store_r && !err_flag_r;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign dbus.dbus_req   = req_r;
    assign dbus.dbus_we    = we_r;
    assign dbus.dbus_addr  = addr_r;
    assign dbus.dbus_be    = be_r;
    assign dbus.dbus_wdata = wdata_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues expected retirements and
// bus requests; a retire monitor and a bus responder pop and compare them.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = OP_ORI;
    logic [31:0] alu_data = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        regc_write_i = 1'b0;
    logic [4:0]  regc_addr_i = 5'd0;
    logic        regc_write;
    logic [4:0]  regc_addr;
    logic [31:0] regc_data;
    logic        stall;
    logic        err;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .aluData     (alu_data),
        .storeData   (store_data),
        .regcWrite_i (regc_write_i),
        .regcAddr_i  (regc_addr_i),
        .regcWrite   (regc_write),
        .regcAddr    (regc_addr),
        .regcData    (regc_data),
        .stall       (stall),
        .err         (err),
        .dbus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
        int          stalls;
    } retire_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_t;

    retire_t     ret_q[$];
    bus_t        bus_q[$];
    int          checks = 0;
    int          passes = 0;
    logic        instr_valid = 1'b0;
    int          ack_delay = 0;
    logic [31:0] resp_rdata = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic retire_t mk_ret(input logic we, input logic [4:0] a, input logic [31:0] d,
                                       input logic e, input int s);
        retire_t r;
        r.we = we; r.addr = a; r.data = d; r.err = e; r.stalls = s;
        return r;
    endfunction

    function automatic bus_t mk_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                                    input logic [31:0] wd, input logic cw);
        bus_t b;
        b.we = we; b.addr = a; b.be = be; b.wdata = wd; b.chk_wdata = cw;
        return b;
    endfunction

    // Retire monitor: an instruction retires on the first non-stalled cycle
    initial begin : retire_mon
        int      stall_cnt;
        logic    prev_retire;
        retire_t r;
        stall_cnt = 0;
        prev_retire = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
                prev_retire = 1'b0;
            end else begin
                if (prev_retire) check32("err_single_cycle", 32'(err), 32'd0);
                prev_retire = 1'b0;
                if (instr_valid) begin
                    if (stall) begin
                        stall_cnt++;
                        check32("no_wb_while_stalled", 32'(regc_write), 32'd0);
                    end else begin
                        if (ret_q.size() == 0) begin
                            checks++;
                            $display("FAIL unexpected_retire: got retire expected none");
                        end else begin
                            r = ret_q.pop_front();
                            check32("regcWrite", 32'(regc_write), 32'(r.we));
                            if (r.we) begin
                                check32("regcAddr", 32'(regc_addr), 32'(r.addr));
                                check32("regcData", regc_data, r.data);
                            end
                            check32("err", 32'(err), 32'(r.err));
                            check32("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
                            check32("req_low_at_retire", 32'(bus.dbus_req), 32'd0);
                        end
                        stall_cnt = 0;
                        prev_retire = 1'b1;
                    end
                end
            end
        end
    end

    // Bus responder: checks each request, acks after ack_delay WAIT cycles
    initial begin : bus_resp
        int   wcnt;
        bus_t b;
        wcnt = 0;
        b = mk_bus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        bus.dbus_ack = 1'b0;
        bus.dbus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.dbus_ack = 1'b0;
            if (bus.dbus_req && !rst) begin
                wcnt++;
                if (wcnt == 1) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_req: got dbus_req=1 expected 0");
                    end else begin
                        b = bus_q.pop_front();
                        check32("dbus_we", 32'(bus.dbus_we), 32'(b.we));
                        check32("dbus_addr", bus.dbus_addr, b.addr);
                        check32("dbus_be", 32'(bus.dbus_be), 32'(b.be));
                        if (b.chk_wdata) check32("dbus_wdata", bus.dbus_wdata, b.wdata);
                    end
                end
                if (wcnt == ack_delay) begin
                    check32("addr_stable_at_ack", bus.dbus_addr, b.addr);
                    check32("be_stable_at_ack", 32'(bus.dbus_be), 32'(b.be));
                    bus.dbus_ack = 1'b1;
                    bus.dbus_rdata = resp_rdata;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] sd,
                         input logic wi, input logic [4:0] ai, input int dly,
                         input logic [31:0] rd, input retire_t r, input logic has_bus, input bus_t b);
        bit done;
        @(posedge clk);
        #1;
        op = o; alu_data = a; store_data = sd; regc_write_i = wi; regc_addr_i = ai;
        ack_delay = dly; resp_rdata = rd;
        if (has_bus) bus_q.push_back(b);
        ret_q.push_back(r);
        instr_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL retire_timeout: got no retire expected one within 100 cycles");
        end
    endtask

    task automatic go_idle(input int n);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        op = OP_SPECIAL; regc_write_i = 1'b0; ack_delay = 0;
        repeat (n) @(negedge clk);
    endtask

    bus_t nb;

    initial begin
        nb = mk_bus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        // Reset state with an ALU op and then a memory op presented
        op = OP_ORI; alu_data = 32'h00001234; regc_write_i = 1'b1; regc_addr_i = 5'd3;
        #12;
        check32("rst_regcWrite", 32'(regc_write), 32'd0);
        check32("rst_regcData", regc_data, 32'd0);
        check32("rst_stall", 32'(stall), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
        check32("rst_req", 32'(bus.dbus_req), 32'd0);
        op = OP_LW; alu_data = 32'h00000040;
        #2;
        check32("rst_stall_memop", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        op = OP_SPECIAL; regc_write_i = 1'b0;
        rst = 1'b0;

        issue(OP_ORI, 32'h00001100, 32'h0, 1'b1, 5'd7, 0, 32'h0,
              mk_ret(1'b1, 5'd7, 32'h00001100, 1'b0, 0), 1'b0, nb);
        issue(OP_ADDIU, 32'h00000055, 32'h0, 1'b0, 5'd4, 0, 32'h0,
              mk_ret(1'b0, 5'd4, 32'h0, 1'b0, 0), 1'b0, nb);
        issue(OP_SW, 32'h00000040, 32'hDEADBEEF, 1'b0, 5'd0, 2, 32'h0,
              mk_ret(1'b0, 5'd0, 32'h0, 1'b0, 3), 1'b1,
              mk_bus(1'b1, 32'h00000040, 4'b1111, 32'hDEADBEEF, 1'b1));
        issue(OP_LW, 32'h00000040, 32'h0, 1'b1, 5'd8, 1, 32'hDEADBEEF,
              mk_ret(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 2), 1'b1,
              mk_bus(1'b0, 32'h00000040, 4'b1111, 32'h0, 1'b0));
        issue(OP_SB, 32'h00000043, 32'h000000A5, 1'b0, 5'd0, 1, 32'h0,
              mk_ret(1'b0, 5'd0, 32'h0, 1'b0, 2), 1'b1,
              mk_bus(1'b1, 32'h00000040, 4'b1000, 32'hA5A5A5A5, 1'b1));
        issue(OP_LB, 32'h00000043, 32'h0, 1'b1, 5'd9, 1, 32'hA5000000,
              mk_ret(1'b1, 5'd9, 32'hFFFFFFA5, 1'b0, 2), 1'b1,
              mk_bus(1'b0, 32'h00000040, 4'b1000, 32'h0, 1'b0));
        issue(OP_LBU, 32'h00000043, 32'h0, 1'b1, 5'd10, 1, 32'hA5000000,
              mk_ret(1'b1, 5'd10, 32'h000000A5, 1'b0, 2), 1'b1,
              mk_bus(1'b0, 32'h00000040, 4'b1000, 32'h0, 1'b0));
        issue(OP_LB, 32'h00000101, 32'h0, 1'b1, 5'd13, 1, 32'h00007F80,
              mk_ret(1'b1, 5'd13, 32'h0000007F, 1'b0, 2), 1'b1,
              mk_bus(1'b0, 32'h00000100, 4'b0010, 32'h0, 1'b0));
        issue(OP_LW, 32'h00000042, 32'h0, 1'b1, 5'd5, 0, 32'h0,
              mk_ret(1'b0, 5'd5, 32'h0, 1'b1, 1), 1'b0, nb);
        issue(OP_LW, 32'h00000080, 32'h0, 1'b1, 5'd6, 0, 32'h0,
              mk_ret(1'b0, 5'd6, 32'h0, 1'b1, 1 + TMO), 1'b1,
              mk_bus(1'b0, 32'h00000080, 4'b1111, 32'h0, 1'b0));
        issue(OP_LW, 32'h00000080, 32'h0, 1'b1, 5'd11, TMO, 32'h12345678,
              mk_ret(1'b1, 5'd11, 32'h12345678, 1'b0, 1 + TMO), 1'b1,
              mk_bus(1'b0, 32'h00000080, 4'b1111, 32'h0, 1'b0));
        go_idle(2);

        // Store left hanging in WAIT, then reset asserted between clock edges
        @(posedge clk);
        #1;
        op = OP_SW; alu_data = 32'h00000200; store_data = 32'h11223344; ack_delay = 0;
        bus_q.push_back(mk_bus(1'b1, 32'h00000200, 4'b1111, 32'h11223344, 1'b1));
        repeat (3) @(negedge clk);
        check32("req_before_reset", 32'(bus.dbus_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check32("async_rst_req", 32'(bus.dbus_req), 32'd0);
        check32("async_rst_we", 32'(bus.dbus_we), 32'd0);
        check32("async_rst_be", 32'(bus.dbus_be), 32'd0);
        check32("async_rst_addr", bus.dbus_addr, 32'd0);
        check32("async_rst_wdata", bus.dbus_wdata, 32'd0);
        check32("async_rst_stall", 32'(stall), 32'd0);
        check32("async_rst_regcWrite", 32'(regc_write), 32'd0);
        @(posedge clk);
        #1;
        op = OP_SPECIAL;
        rst = 1'b0;

        issue(OP_LW, 32'h00000040, 32'h0, 1'b1, 5'd12, 1, 32'hCAFEF00D,
              mk_ret(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 2), 1'b1,
              mk_bus(1'b0, 32'h00000040, 4'b1111, 32'h0, 1'b0));
        go_idle(3);

        check32("ret_queue_drained", 32'(ret_q.size()), 32'd0);
        check32("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
